// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives a 1-cycle sync-read imem, queues words for decode.
// Latency issue->inst_valid 2 cycles; fetch stalls when queue plus in-flight read would exceed 2 entries.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [31:0]        inst_pc,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               fault,
  output logic [31:0]        fault_pc
);

  typedef enum logic [1:0] {START, RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pending;
  logic [1:0]  count;
  logic        head;
  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];

  logic       in_run;
  logic       pop;
  logic [2:0] occ;
  logic       would_issue;
  logic       range_bad;
  logic       range_fault;
  logic       issue;
  logic       redir;
  logic       redir_fault;
  logic       wr_idx;

  assign inst_valid = (count != 2'd0);
  assign inst_data  = q_data[head];
  assign inst_pc    = q_pc[head];

  assign in_run = (state == RUN) && !reset;
  assign pop    = inst_valid && inst_ready;
  // Occupancy after this cycle's pop; the in-flight read already owns a slot.
  assign occ    = {1'b0, count} + {2'b00, pending} - {2'b00, pop};

  assign would_issue = in_run && !halt && !redirect_valid && (occ < 3'd2);
  assign range_bad   = |pc[31:IMEM_AW+2];
  assign range_fault = would_issue && range_bad;
  assign issue       = would_issue && !range_bad;
  assign redir       = in_run && redirect_valid;
  assign redir_fault = redir && (redirect_pc[1:0] != 2'b00);
  assign wr_idx      = head ^ count[0];

  assign imem_en   = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= START;
      pc       <= RESET_PC;
      pend_pc  <= 32'h0;
      pending  <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= 32'h0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= 32'h0;
        q_pc[i]   <= 32'h0;
      end
    end else begin
      case (state)
        START: state <= RUN;
        RUN: begin
          if (redir_fault || range_fault) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= redir_fault ? redirect_pc : pc;
            count    <= 2'd0;
            pending  <= 1'b0;
          end else if (redir) begin
            // Same-cycle pop is already complete on the decode side; the rest is dropped.
            pc      <= redirect_pc;
            count   <= 2'd0;
            pending <= 1'b0;
          end else begin
            pending <= issue;
            if (issue) begin
              pc      <= pc + 32'd4;
              pend_pc <= pc;
            end
            if (pending) begin
              q_data[wr_idx] <= imem_rdata;
              q_pc[wr_idx]   <= pend_pc;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, pending} - {1'b0, pop};
          end
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized phase scored against an in-order stream model.
// The memory returns 0x1000_0000 + word index, so every delivered word identifies its own address.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: next pc to be delivered, next pc to be fetched, words owed to decode.
  logic [31:0] exp_pc;
  logic [31:0] fetch_pc;
  int          outstanding;
  bit          mdl_on;
  int          pops;

  fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_en) imem_rdata <= 32'h1000_0000 + {22'b0, imem_addr};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (imem_en) begin
      chk("fetch_addr", {22'b0, imem_addr}, {22'b0, fetch_pc[11:2]});
      fetch_pc = fetch_pc + 32'd4;
      outstanding++;
    end
    if (inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, 32'h1000_0000 + (exp_pc >> 2));
    end
    if (inst_valid && inst_ready) begin
      exp_pc = exp_pc + 32'd4;
      outstanding--;
      pops++;
    end
    if (halt || redirect_valid) chk("fetch_blocked", {31'b0, imem_en}, 32'd0);
    chk("fault_clear", {31'b0, fault}, 32'd0);
    chk("occupancy_le2", {31'b0, (outstanding <= 2)}, 32'd1);
    if (redirect_valid) begin
      exp_pc      = redirect_pc;
      fetch_pc    = redirect_pc;
      outstanding = 0;
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample settled outputs, score them.
  task automatic cyc(input logic rst, input logic rdy, input logic hlt,
                     input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset = rst; inst_ready = rdy; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (rst) begin
      exp_pc = RESET_PC; fetch_pc = RESET_PC; outstanding = 0;
    end else if (mdl_on) begin
      model();
    end
  endtask

  // Two reset cycles, then ends sampling the START cycle.
  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int halt_pops;
    logic rdy, hlt, rv;
    mdl_on = 1'b1;
    pops = 0;

    // Reset state and release timing.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("start_no_fetch", {31'b0, imem_en}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_fetch_en", {31'b0, imem_en}, 32'd1);
    chk("first_fetch_addr", {22'b0, imem_addr}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_not_yet_valid", {31'b0, inst_valid}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_pc", inst_pc, 32'd0);

    // Streaming without bubbles.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stream_no_bubble", {31'b0, inst_valid}, 32'd1);
    end

    // Backpressure: queue fills, fetch stops, head holds.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("full_no_fetch", {31'b0, imem_en}, 32'd0);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("release_no_bubble", {31'b0, inst_valid}, 32'd1);
    end

    // Redirect while the read for 0x8 is in flight.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_redirect_fetch_8", {22'b0, imem_addr}, 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6 && !inst_valid; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_arrived", {31'b0, inst_valid}, 32'd1);
    chk("redir_first_pc", inst_pc, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_second_pc", inst_pc, 32'h44);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Halt mid-stream: head and in-flight word delivered, then nothing.
    halt_pops = pops;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("halt_delivered", pops - halt_pops, 32'd2);
    chk("halt_drained", {31'b0, inst_valid}, 32'd0);

    // Refill under backpressure, then reset with two entries queued.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("refill_valid", {31'b0, inst_valid}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("reset_flush_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset_flush_data", inst_data, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("restart_en", {31'b0, imem_en}, 32'd1);
    chk("restart_addr", {22'b0, imem_addr}, {22'b0, RESET_PC[11:2]});

    // Randomized phase against the stream model; targets stay well inside memory.
    do_reset();
    halt_pops = pops;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      cyc(1'b0, rdy, hlt, rv, {20'b0, 10'($urandom_range(0, 511)), 2'b00});
    end
    chk("random_progress", {31'b0, (pops - halt_pops > 50)}, 32'd1);

    // Misaligned redirect fault; later redirects ignored.
    mdl_on = 1'b0;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
    chk("misalign_no_fetch", {31'b0, imem_en}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("misalign_fault", {31'b0, fault}, 32'd1);
    chk("misalign_fault_pc", fault_pc, 32'h42);
    chk("misalign_no_valid", {31'b0, inst_valid}, 32'd0);
    chk("misalign_en_off", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
      chk("fault_sticky_en", {31'b0, imem_en}, 32'd0);
      chk("fault_sticky_pc", fault_pc, 32'h42);
      chk("fault_sticky_valid", {31'b0, inst_valid}, 32'd0);
    end

    // Out-of-range redirect faults on the would-be fetch.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1000);
    chk("range_redirect_ok", {31'b0, fault}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("range_no_fetch", {31'b0, imem_en}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("range_fault", {31'b0, fault}, 32'd1);
    chk("range_fault_pc", fault_pc, 32'h1000);
    chk("range_en_off", {31'b0, imem_en}, 32'd0);
    chk("range_no_valid", {31'b0, inst_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
